// File: rtl/aes_pkg.sv
// ============================================================================
// aes_pkg : shared AES-128 types, round-constant lookup and RotWord helper.
// Rev 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int NR = 10;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } key_state_t;

  // Indexed by the round being produced; anything outside 1..10 has no rcon.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sbox.sv
// ============================================================================
// sbox : AES forward S-box, purely combinational byte substitution.
// Rev 1.0
// ============================================================================
`default_nettype none

module sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Row-major table; element 0 sits in the most significant byte.
  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = SBOX_TABLE[din];

endmodule

`default_nettype wire

// File: rtl/aes_key_expand.sv
// ============================================================================
// aes_key_expand : iterative AES-128 key schedule, one round key per handshake.
// Rev 1.0
// ============================================================================
`default_nettype none

module aes_key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_out,
  output logic         done
);

  key_state_t state_q, state_d;
  aes_block_t rk_q, rk_d;
  logic [3:0] round_q, round_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  aes_word_t  rot_w3;
  aes_word_t  sub_w3;
  aes_word_t  t_word;
  aes_word_t  w4, w5, w6, w7;
  aes_block_t next_rk;

  assign rot_w3 = rot_word(rk_q[31:0]);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    sbox u_sbox (
      .din  (rot_w3[8*i +: 8]),
      .dout (sub_w3[8*i +: 8])
    );
  end

  // Next round key derived from the registered key, so the loop stays one step deep.
  always_comb begin
    t_word  = sub_w3 ^ {rcon(round_q + 4'd1), 24'h0};
    w4      = rk_q[127:96] ^ t_word;
    w5      = w4 ^ rk_q[95:64];
    w6      = w5 ^ rk_q[63:32];
    w7      = w6 ^ rk_q[31:0];
    next_rk = {w4, w5, w6, w7};
  end

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          rk_d    = key_in;
          round_d = 4'd0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (valid_q && rk_ready) begin
          if (round_q == 4'(NR)) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            rk_d    = next_rk;
            round_d = round_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rk_q    <= '0;
      round_q <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign rk_valid = valid_q;
  assign rk_round = round_q;
  assign rk_out   = rk_q;
  assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expand.sv
// ============================================================================
// tb_aes_key_expand : directed, table-driven check of the AES-128 key schedule.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_aes_key_expand;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         busy;
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic [127:0] rk_out;
  logic         done;

  aes_key_expand dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .rk_ready (rk_ready),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_round (rk_round),
    .rk_out   (rk_out),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    int           rnd;
    logic [127:0] rk;
  } vec_t;

  vec_t vecs[14];

  int total = 0;
  int bad   = 0;

  logic [127:0] got_rk [0:10];
  int n_hs, last_hs_cyc, order_err, stall_err, early_done;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " busy"},     busy,     0);
    chk({tag, " rk_valid"}, rk_valid, 0);
    chk({tag, " done"},     done,     0);
    chk({tag, " rk_round"}, rk_round, 0);
    chk({tag, " rk_out"},   rk_out,   0);
  endtask

  // Runs one schedule, sampling and driving on the falling edge. A handshake is
  // counted when rk_valid and the rk_ready just driven will both be seen at the
  // next rising edge. Ends on the cycle done should be high (or right after an abort).
  task automatic run_sched(input logic [127:0] k, input bit do_start, input int max_stall,
                           input int restart_round, input logic [127:0] k2,
                           input int abort_round);
    int           stall;
    int           cyc;
    bit           prev_stalled;
    bit           restarted;
    logic [127:0] prev_rk;
    logic [3:0]   prev_rd;
    n_hs = 0; last_hs_cyc = -1; order_err = 0; stall_err = 0; early_done = 0;
    prev_stalled = 1'b0; restarted = 1'b0; prev_rk = '0; prev_rd = '0;
    for (int r = 0; r <= 10; r++) got_rk[r] = 'x;
    stall = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
    if (do_start) begin
      start = 1'b1; key_in = k;
      @(negedge clk);
      start = 1'b0; key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    cyc = 0;
    while (n_hs < 11 && cyc < 400) begin
      if (prev_stalled && (rk_out !== prev_rk || rk_round !== prev_rd)) stall_err++;
      if (done) early_done++;
      if (abort_round >= 0 && rk_valid && int'(rk_round) == abort_round) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (stall > 0) begin rk_ready = 1'b0; stall--; end
      else rk_ready = 1'b1;
      if (restart_round >= 0 && !restarted && rk_valid && int'(rk_round) == restart_round) begin
        start = 1'b1; key_in = k2; restarted = 1'b1;
      end
      if (rk_valid && rk_ready) begin
        if (int'(rk_round) != n_hs) order_err++;
        if (rk_round <= 4'd10) got_rk[rk_round] = rk_out;
        n_hs++;
        last_hs_cyc = cyc;
        stall = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
      end
      prev_stalled = rk_valid && !rk_ready;
      prev_rk = rk_out; prev_rd = rk_round;
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk("handshake count", n_hs, 11);
    chk("round order errors", order_err, 0);
    chk("early done", early_done, 0);
    chk("done pulse", done, 1);
    chk("busy after last", busy, 0);
    chk("valid after last", rk_valid, 0);
  endtask

  initial begin
    logic [127:0] cur_key;
    bit           have;

    vecs[0]  = '{FIPS_KEY, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[1]  = '{FIPS_KEY, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2]  = '{FIPS_KEY, 2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3]  = '{FIPS_KEY, 3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    vecs[4]  = '{FIPS_KEY, 4,  128'hef44a541a8525b7fb671253bdb0bad00};
    vecs[5]  = '{FIPS_KEY, 5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    vecs[6]  = '{FIPS_KEY, 6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    vecs[7]  = '{FIPS_KEY, 7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    vecs[8]  = '{FIPS_KEY, 8,  128'head27321b58dbad2312bf5607f8d292f};
    vecs[9]  = '{FIPS_KEY, 9,  128'hac7766f319fadc2128d12941575c006e};
    vecs[10] = '{FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[11] = '{ZERO_KEY, 0,  128'h0};
    vecs[12] = '{ZERO_KEY, 1,  128'h62636363626363636263636362636363};
    vecs[13] = '{ZERO_KEY, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; key_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("reset");

    // Unstalled schedules, one run per key in the table.
    have = 1'b0; cur_key = '0;
    for (int i = 0; i < 14; i++) begin
      if (!have || vecs[i].key !== cur_key) begin
        run_sched(vecs[i].key, 1'b1, 0, -1, '0, -1);
        chk("last handshake cycle", last_hs_cyc, 10);
        @(negedge clk);
        chk("done one cycle", done, 0);
        cur_key = vecs[i].key; have = 1'b1;
      end
      chk($sformatf("rk key=%h r%0d", vecs[i].key[127:96], vecs[i].rnd),
          got_rk[vecs[i].rnd], vecs[i].rk);
    end

    // Random back-pressure must not change the sequence.
    run_sched(FIPS_KEY, 1'b1, 5, -1, '0, -1);
    chk("stall stability errors", stall_err, 0);
    for (int i = 0; i < 11; i++)
      chk($sformatf("stalled r%0d", vecs[i].rnd), got_rk[vecs[i].rnd], vecs[i].rk);
    @(negedge clk);

    // New start mid-schedule is ignored.
    run_sched(FIPS_KEY, 1'b1, 0, 4, ZERO_KEY, -1);
    chk("restart ignored r5", got_rk[5], vecs[5].rk);
    chk("restart ignored r10", got_rk[10], vecs[10].rk);

    // Start in the done cycle is accepted.
    start = 1'b1; key_in = ZERO_KEY;
    @(negedge clk);
    start = 1'b0;
    chk("done-cycle start valid", rk_valid, 1);
    chk("done-cycle start busy", busy, 1);
    chk("done-cycle start round", rk_round, 0);
    run_sched(ZERO_KEY, 1'b0, 0, -1, '0, -1);
    chk("done-cycle start r1", got_rk[1], vecs[12].rk);
    chk("done-cycle start r10", got_rk[10], vecs[13].rk);
    @(negedge clk);

    // Reset at round 6 aborts without a done pulse.
    run_sched(FIPS_KEY, 1'b1, 0, -1, '0, 6);
    check_reset_outputs("abort");
    @(negedge clk);
    chk("abort no done", done, 0);
    chk("abort early done", early_done, 0);
    run_sched(FIPS_KEY, 1'b1, 0, -1, '0, -1);
    chk("post-abort r0", got_rk[0], vecs[0].rk);
    chk("post-abort r10", got_rk[10], vecs[10].rk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES-128 key-schedule generator. On `start` it latches a 128-bit cipher key and streams the 11 round keys (round 0 to round 10) over a valid/ready interface, one per handshake. It sits directly downstream of the S-box: four `sbox` instances perform SubWord on the rotated last word. Its output feeds the AddRoundKey stage of the round datapath.

## Interface
- No parameters. Key size is fixed at 128 bits and Nr = 10.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: request a new key schedule; honoured only when `busy`=0.
- `key_in` input 128: cipher key, sampled on the accepted `start` edge; [127:96] is w0.
- `rk_ready` input 1: consumer accepts `rk_out` this cycle.
- `busy` output 1: schedule in progress.
- `rk_valid` output 1: `rk_out`/`rk_round` hold a valid round key.
- `rk_round` output 4: index of the round key presented (0 to 10).
- `rk_out` output 128: round key, words w[4r] at [127:96] down to w[4r+3] at [31:0].
- `done` output 1: one-cycle pulse after round key 10 is accepted.

## Operation
- The state machine has two states: IDLE and RUN.
- IDLE with `start`=1 -> RUN.
  - Set `rk_out`←`key_in`, `rk_round`←0, `rk_valid`←1, `busy`←1.
- RUN with `rk_valid`&`rk_ready` and `rk_round`<10:
  - `rk_out`←next(`rk_out`, rcon[`rk_round`+1]).
  - `rk_round`←`rk_round`+1.
  - `rk_valid` stays 1.
- RUN with `rk_valid`&`rk_ready` and `rk_round`=10 -> IDLE.
  - Set `rk_valid`←0, `busy`←0, `done`←1 for exactly one cycle.
- RUN with `rk_ready`=0: hold all outputs unchanged (back-pressure of any length).
- next() is computed combinationally from the registered `rk_out`:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - RotWord(w) = {w[23:0], w[31:24]}; SubWord applies `sbox` to each byte.
  - w4 = w0^t, w5 = w4^w1, w6 = w5^w2, w7 = w6^w3.
- rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. All arithmetic is bitwise XOR; no carries.
- `start` while `busy`=1 is ignored. This includes the cycle of the final handshake.
- `start` in the `done` cycle is accepted, because the block is already in IDLE.
- `key_in` is don't-care except on the accepted `start` edge.

## Timing
- Reset (`rst_n`=0 at a clock edge) forces:
  - state IDLE; `busy`=0, `rk_valid`=0, `done`=0;
  - `rk_round`=0, `rk_out`=128'h0.
- Reset mid-schedule aborts the schedule. Outputs take their reset values after that edge; no `done` pulse.
- Start latency: `start` sampled at edge N -> `rk_valid`=1 with round 0 from edge N onward (visible in cycle N+1).
- Each handshake at edge M -> the next round key is registered at edge M; there are no bubbles.
- With `rk_ready` held at 1, a full schedule takes 11 cycles, and `done` is high in cycle 12.
- Critical path: `rk_out` → `sbox` → XOR chain (4 deep) → `rk_out`.

## Structure
- Shared package `aes_pkg`:
  - `NR` = 10;
  - `aes_word_t` (32-bit) and `aes_block_t` (128-bit) typedefs;
  - rcon lookup function indexed 1 to 10 (returns 8'h00 for out-of-range indices);
  - RotWord helper function.
- Sub-module: the existing `sbox`, instantiated four times (one per byte of RotWord(w3)).
- The key-step logic stays inline. No separate storage for the 11 keys; the consumer buffers them if needed.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1:
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - 11 consecutive valid cycles; `done` 1 cycle later.
- All-zero key:
  - round 1 = 62636363626363636263636362636363;
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Back-pressure: deassert `rk_ready` randomly for 0 to 5 cycles per round.
  - `rk_out`/`rk_round` stay stable while stalled.
  - The sequence is identical to the unstalled run.
- Re-start:
  - Pulse `start` with a different key at round 4 -> ignored; the schedule completes for the original key.
  - `start` in the `done` cycle -> new round 0 the following cycle.
- Reset at round 6 (`rst_n`=0 for one edge):
  - all outputs return to reset values; no `done`;
  - a subsequent `start` produces a correct full schedule.
- Reset values after power-up reset: `busy`=0, `rk_valid`=0, `done`=0, `rk_round`=0, `rk_out`=0.
